// File: rtl/dmem_arbiter.sv
// dmem_arbiter - shares the single-port, 1-cycle-read-latency data RAM between
// the core LSU (master 0) and the debug/program-loader port (master 1).
// At most one access per cycle is issued. Grants are combinational so a
// request is issued to memory in the cycle it is accepted. Read data returns
// to the owning master one cycle later. Bounded locked bursts let one master
// keep ownership for up to LOCK_MAX grants while the other master waits.
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration on
// contention. When it is left undefined, master 0 always wins on contention.
// Forced lock release applies in both builds.

module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int LOCK_MAX = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   // master 0 (core LSU)
   input  logic              i_m0_req,
   input  logic              i_m0_we,
   input  logic [ADDR_W-1:0] i_m0_addr,
   input  logic [31:0]       i_m0_wdata,
   input  logic [3:0]        i_m0_bmask,
   input  logic              i_m0_lock,
   output logic              o_m0_gnt,
   output logic              o_m0_rvalid,
   output logic [31:0]       o_m0_rdata,
   // master 1 (debug / program loader)
   input  logic              i_m1_req,
   input  logic              i_m1_we,
   input  logic [ADDR_W-1:0] i_m1_addr,
   input  logic [31:0]       i_m1_wdata,
   input  logic [3:0]        i_m1_bmask,
   input  logic              i_m1_lock,
   output logic              o_m1_gnt,
   output logic              o_m1_rvalid,
   output logic [31:0]       o_m1_rdata,
   // data memory
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic [3:0]        o_mem_bmask,
   input  logic [31:0]       i_mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   // Last lock count value before a competing request forces release.
   localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);

   state_t            state_r;
   logic [7:0]        lock_cnt_r;
   logic              force_vld_r;   // a forced release just happened
   logic              force_sel_r;   // master that must win the next contention
   logic              rd_pend_r;
   logic              rd_owner_r;    // 0 = master 0, 1 = master 1
`ifdef DMEM_ARB_RR_EN
   logic              rr_ptr_r;      // master preferred on the next contention
`endif

   logic              pick0_s;
   logic              pick1_s;
   logic              gnt0_s;
   logic              gnt1_s;
   logic              arb_s;         // grant came from a fresh arbitration
   logic              any_gnt_s;
   logic              own_lock_s;
   logic              other_req_s;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [31:0]       mem_wdata_s;
   logic [3:0]        mem_bmask_s;

   // Free arbitration between the two requesters (forced winner, then policy).
   always_comb begin
      pick0_s = 1'b0;
      pick1_s = 1'b0;
      if (i_m0_req && i_m1_req) begin
         if (force_vld_r) begin
            pick0_s = ~force_sel_r;
            pick1_s = force_sel_r;
         end else begin
`ifdef DMEM_ARB_RR_EN
            pick0_s = ~rr_ptr_r;
            pick1_s = rr_ptr_r;
`else
            pick0_s = 1'b1;
            pick1_s = 1'b0;
`endif
         end
      end else begin
         pick0_s = i_m0_req;
         pick1_s = i_m1_req;
      end
   end

   // Grant selection: a requesting lock owner keeps the port; an owner that
   // stops requesting hands the port to free arbitration in the same cycle.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      arb_s  = 1'b0;
      if (i_reset) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               gnt0_s = pick0_s;
               gnt1_s = pick1_s;
               arb_s  = pick0_s | pick1_s;
            end
            ST_OWN0: begin
               if (i_m0_req) begin
                  gnt0_s = 1'b1;
               end else begin
                  gnt1_s = i_m1_req;
                  arb_s  = i_m1_req;
               end
            end
            ST_OWN1: begin
               if (i_m1_req) begin
                  gnt1_s = 1'b1;
               end else begin
                  gnt0_s = i_m0_req;
                  arb_s  = i_m0_req;
               end
            end
            default: begin
               gnt0_s = 1'b0;
               gnt1_s = 1'b0;
            end
         endcase
      end
   end

   assign any_gnt_s = gnt0_s | gnt1_s;

   // Lock request of the granted master and request of the waiting master.
   always_comb begin
      own_lock_s  = 1'b0;
      other_req_s = 1'b0;
      if (gnt0_s) begin
         own_lock_s  = i_m0_lock;
         other_req_s = i_m1_req;
      end else begin
         own_lock_s  = i_m1_lock;
         other_req_s = i_m0_req;
      end
   end

   // Route the granted master's access to the memory port; idle port is all 0.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_addr_s  = '0;
      mem_wdata_s = 32'd0;
      mem_bmask_s = 4'd0;
      if (gnt0_s) begin
         mem_we_s    = i_m0_we;
         mem_addr_s  = i_m0_addr;
         mem_wdata_s = i_m0_wdata;
         mem_bmask_s = i_m0_bmask;
      end else if (gnt1_s) begin
         mem_we_s    = i_m1_we;
         mem_addr_s  = i_m1_addr;
         mem_wdata_s = i_m1_wdata;
         mem_bmask_s = i_m1_bmask;
      end else begin
         mem_we_s    = 1'b0;
      end
   end

   // Ownership state, lock counter, forced-release memory and read tracking.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r     <= ST_IDLE;
         lock_cnt_r  <= 8'd0;
         force_vld_r <= 1'b0;
         force_sel_r <= 1'b0;
         rd_pend_r   <= 1'b0;
         rd_owner_r  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
         rr_ptr_r    <= 1'b0;
`endif
      end else begin
         rd_pend_r   <= any_gnt_s & ~mem_we_s;
         rd_owner_r  <= gnt1_s;
         force_vld_r <= 1'b0;
         if (any_gnt_s && own_lock_s) begin
            if (arb_s) begin
               // new lock: this grant is the first of the burst
               state_r    <= gnt1_s ? ST_OWN1 : ST_OWN0;
               lock_cnt_r <= 8'd1;
            end else if (lock_cnt_r != CNT_LAST) begin
               lock_cnt_r <= lock_cnt_r + 8'd1;
            end else if (other_req_s) begin
               // burst limit hit with a waiter: it wins the next arbitration
               state_r     <= ST_IDLE;
               lock_cnt_r  <= 8'd0;
               force_vld_r <= 1'b1;
               force_sel_r <= gnt0_s;
            end else begin
               // nobody waiting: counter stays saturated, ownership continues
               lock_cnt_r  <= lock_cnt_r;
            end
         end else begin
            state_r    <= ST_IDLE;
            lock_cnt_r <= 8'd0;
         end
`ifdef DMEM_ARB_RR_EN
         // only arbitration grants move the pointer, locked cycles do not
         if (arb_s) begin
            rr_ptr_r <= gnt0_s;
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
`endif
      end
   end

   assign o_m0_gnt    = gnt0_s;
   assign o_m1_gnt    = gnt1_s;
   assign o_mem_en    = any_gnt_s;
   assign o_mem_we    = mem_we_s;
   assign o_mem_addr  = mem_addr_s;
   assign o_mem_wdata = mem_wdata_s;
   assign o_mem_bmask = mem_bmask_s;

   // A pending read is dropped while reset is held.
   assign o_m0_rvalid = rd_pend_r & ~rd_owner_r & ~i_reset;
   assign o_m1_rvalid = rd_pend_r &  rd_owner_r & ~i_reset;
   assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : 32'd0;
   assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter - directed vector table plus hand-written lock and reset
// sequences for dmem_arbiter (built with LOCK_MAX = 4). Expected grant orders
// follow DMEM_ARB_RR_EN when the bench is compiled with it.

module tb_dmem_arbiter;

   typedef struct {
      logic        rst;
      logic        r0;
      logic        w0;
      logic [31:0] a0;
      logic [31:0] d0;
      logic [3:0]  b0;
      logic        r1;
      logic [31:0] a1;
      logic        g0;
      logic        g1;
      logic        v0;
      logic        v1;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [31:0] maddr;
      logic        mwe;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_bmask, m1_bmask;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_bmask;

   logic [31:0] mem [0:127];
   vec_t        vecs [$];
   int          n_tests;
   int          n_fail;

   dmem_arbiter #(.ADDR_W(32), .LOCK_MAX(4)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
      .i_m0_bmask(m0_bmask), .i_m0_lock(m0_lock),
      .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
      .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
      .i_m1_bmask(m1_bmask), .i_m1_lock(m1_lock),
      .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_bmask[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end else if (mem_en) begin
         mem_rdata <= mem[mem_addr[8:2]];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_bmask = 4'd0; m0_lock = 1'b0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_bmask = 4'd0; m1_lock = 1'b0;
   endtask

   task automatic do_reset();
      step();
      clear_in();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic add(input logic rst_i, input logic r0, input logic w0, input logic [31:0] a0,
                      input logic [31:0] d0, input logic [3:0] b0, input logic r1, input logic [31:0] a1,
                      input logic g0, input logic g1, input logic v0, input logic v1,
                      input logic [31:0] rd0, input logic [31:0] rd1, input logic [31:0] maddr,
                      input logic mwe);
      vec_t v;
      v.rst = rst_i; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.b0 = b0; v.r1 = r1; v.a1 = a1;
      v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1; v.maddr = maddr; v.mwe = mwe;
      vecs.push_back(v);
   endtask

   // Locked write burst by one master while the other waits with a read.
   task automatic lock_seq(input logic own1);
      logic [3:0] k;
      logic       oth_done, eo, ex, oreq;
      logic [31:0] oaddr, odata;
      string      tag;
      tag = own1 ? "lock1" : "lock0";
      do_reset();
      k = 4'd0;
      oth_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
         step();
         clear_in();
         oreq  = (k < 4'd8);
         oaddr = 32'h0000_0100 + {26'd0, k, 2'b00};
         odata = 32'h0000_00A0 + {28'd0, k};
         if (own1) begin
            m1_req = oreq; m1_we = 1'b1; m1_lock = 1'b1; m1_addr = oaddr; m1_wdata = odata; m1_bmask = 4'hF;
            m0_req = (c >= 1) && !oth_done; m0_addr = 32'h14;
         end else begin
            m0_req = oreq; m0_we = 1'b1; m0_lock = 1'b1; m0_addr = oaddr; m0_wdata = odata; m0_bmask = 4'hF;
            m1_req = (c >= 1) && !oth_done; m1_addr = 32'h14;
         end
         @(negedge clk);
         eo = (c < 4) || (c >= 5 && c < 9);
         ex = (c == 4);
         chk($sformatf("%s c%0d gnt0", tag, c), {31'd0, m0_gnt}, {31'd0, own1 ? ex : eo});
         chk($sformatf("%s c%0d gnt1", tag, c), {31'd0, m1_gnt}, {31'd0, own1 ? eo : ex});
         if (c == 0) begin
            chk($sformatf("%s c0 mem_we", tag), {31'd0, mem_we}, 32'd1);
            chk($sformatf("%s c0 mem_wdata", tag), mem_wdata, 32'h0000_00A0);
         end
         if (c == 4) chk($sformatf("%s c4 mem_addr", tag), mem_addr, 32'h14);
         if (c == 5) begin
            chk($sformatf("%s c5 mem_addr", tag), mem_addr, 32'h110);
            chk($sformatf("%s c5 waiter rvalid", tag), {31'd0, own1 ? m0_rvalid : m1_rvalid}, 32'd1);
            chk($sformatf("%s c5 waiter rdata", tag), own1 ? m0_rdata : m1_rdata, 32'h1000_0005);
         end
         if (eo) k = k + 4'd1;
         if (ex) oth_done = 1'b1;
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      n_tests = 0;
      n_fail = 0;
      clear_in();
      for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | i;
      mem[4] = 32'hDEAD_BEEF;

      //   rst r0 w0 a0      d0     b0    r1 a1       g0 g1 v0 v1 rd0            rd1            maddr  mwe
      add(1, 1, 0, 32'h10, 32'd0, 4'h0, 1, 32'h18,  0, 0, 0, 0, 32'd0,         32'd0,         32'h0,  0);
      add(1, 0, 0, 32'h0,  32'd0, 4'h0, 0, 32'h0,   0, 0, 0, 0, 32'd0,         32'd0,         32'h0,  0);
      add(0, 1, 0, 32'h10, 32'd0, 4'h0, 0, 32'h0,   1, 0, 0, 0, 32'd0,         32'd0,         32'h10, 0);
      add(0, 0, 0, 32'h0,  32'd0, 4'h0, 0, 32'h0,   0, 0, 1, 0, 32'hDEADBEEF,  32'd0,         32'h0,  0);
      add(1, 0, 0, 32'h0,  32'd0, 4'h0, 0, 32'h0,   0, 0, 0, 0, 32'd0,         32'd0,         32'h0,  0);
      add(0, 1, 0, 32'h14, 32'd0, 4'h0, 1, 32'h18,  1, 0, 0, 0, 32'd0,         32'd0,         32'h14, 0);
`ifdef DMEM_ARB_RR_EN
      add(0, 1, 0, 32'h14, 32'd0, 4'h0, 1, 32'h18,  0, 1, 1, 0, 32'h10000005,  32'd0,         32'h18, 0);
      add(0, 1, 0, 32'h14, 32'd0, 4'h0, 1, 32'h18,  1, 0, 0, 1, 32'd0,         32'h10000006,  32'h14, 0);
      add(0, 1, 0, 32'h14, 32'd0, 4'h0, 1, 32'h18,  0, 1, 1, 0, 32'h10000005,  32'd0,         32'h18, 0);
      add(0, 0, 0, 32'h0,  32'd0, 4'h0, 0, 32'h0,   0, 0, 0, 1, 32'd0,         32'h10000006,  32'h0,  0);
`else
      add(0, 1, 0, 32'h14, 32'd0, 4'h0, 1, 32'h18,  1, 0, 1, 0, 32'h10000005,  32'd0,         32'h14, 0);
      add(0, 1, 0, 32'h14, 32'd0, 4'h0, 1, 32'h18,  1, 0, 1, 0, 32'h10000005,  32'd0,         32'h14, 0);
      add(0, 1, 0, 32'h14, 32'd0, 4'h0, 1, 32'h18,  1, 0, 1, 0, 32'h10000005,  32'd0,         32'h14, 0);
      add(0, 0, 0, 32'h0,  32'd0, 4'h0, 0, 32'h0,   0, 0, 1, 0, 32'h10000005,  32'd0,         32'h0,  0);
`endif
      add(0, 1, 1, 32'h20, 32'h55, 4'h1, 0, 32'h0,   1, 0, 0, 0, 32'd0,         32'd0,         32'h20, 1);
      add(0, 1, 0, 32'h20, 32'd0, 4'h0, 0, 32'h0,   1, 0, 0, 0, 32'd0,         32'd0,         32'h20, 0);
      add(0, 0, 0, 32'h0,  32'd0, 4'h0, 0, 32'h0,   0, 0, 1, 0, 32'h10000055,  32'd0,         32'h0,  0);

      foreach (vecs[i]) begin
         step();
         clear_in();
         rst = vecs[i].rst;
         m0_req = vecs[i].r0; m0_we = vecs[i].w0; m0_addr = vecs[i].a0;
         m0_wdata = vecs[i].d0; m0_bmask = vecs[i].b0;
         m1_req = vecs[i].r1; m1_addr = vecs[i].a1;
         @(negedge clk);
         chk($sformatf("vec%0d gnt0", i), {31'd0, m0_gnt}, {31'd0, vecs[i].g0});
         chk($sformatf("vec%0d gnt1", i), {31'd0, m1_gnt}, {31'd0, vecs[i].g1});
         chk($sformatf("vec%0d rvalid0", i), {31'd0, m0_rvalid}, {31'd0, vecs[i].v0});
         chk($sformatf("vec%0d rvalid1", i), {31'd0, m1_rvalid}, {31'd0, vecs[i].v1});
         chk($sformatf("vec%0d rdata0", i), m0_rdata, vecs[i].rd0);
         chk($sformatf("vec%0d rdata1", i), m1_rdata, vecs[i].rd1);
         chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].maddr);
         chk($sformatf("vec%0d mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].mwe});
         chk($sformatf("vec%0d mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].g0 | vecs[i].g1});
      end

      // Locked bursts with forced release in both directions.
      lock_seq(1'b1);
      lock_seq(1'b0);

      // Uncontended lock saturates; a late competitor then forces release.
      do_reset();
      for (int c = 0; c < 23; c++) begin
         step();
         clear_in();
         m1_req = (c <= 21); m1_we = 1'b1; m1_lock = 1'b1; m1_bmask = 4'hF;
         m1_addr = 32'h180 + 32'(4 * (c % 8)); m1_wdata = 32'(c);
         m0_req = (c == 20) || (c == 21); m0_addr = 32'h14;
         @(negedge clk);
         chk($sformatf("sat c%0d gnt1", c), {31'd0, m1_gnt}, {31'd0, c <= 20});
         chk($sformatf("sat c%0d gnt0", c), {31'd0, m0_gnt}, {31'd0, c == 21});
      end

      // Reset while a read is pending, then contention right after release.
      do_reset();
      step();
      clear_in();
      m0_req = 1'b1; m0_addr = 32'h10;
      @(negedge clk);
      chk("rst_mid read gnt0", {31'd0, m0_gnt}, 32'd1);
      step();
      rst = 1'b1; m1_req = 1'b1; m1_addr = 32'h18;
      @(negedge clk);
      chk("rst_mid rvalid0", {31'd0, m0_rvalid}, 32'd0);
      chk("rst_mid rdata0", m0_rdata, 32'd0);
      chk("rst_mid gnt0", {31'd0, m0_gnt}, 32'd0);
      chk("rst_mid gnt1", {31'd0, m1_gnt}, 32'd0);
      chk("rst_mid mem_en", {31'd0, mem_en}, 32'd0);
      step();
      @(negedge clk);
      chk("rst_hold gnt0", {31'd0, m0_gnt}, 32'd0);
      chk("rst_hold gnt1", {31'd0, m1_gnt}, 32'd0);
      chk("rst_hold rvalid0", {31'd0, m0_rvalid}, 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rel gnt0", {31'd0, m0_gnt}, 32'd1);
      chk("rst_rel gnt1", {31'd0, m1_gnt}, 32'd0);
      step();
      clear_in();
      @(negedge clk);
      chk("rst_rel rvalid0", {31'd0, m0_rvalid}, 32'd1);
      chk("rst_rel rdata0", m0_rdata, 32'hDEAD_BEEF);
      chk("rst_rel rvalid1", {31'd0, m1_rvalid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter sharing the single-port, 1-cycle-read-latency data memory between the core LSU (master 0) and the debug/program-loader port (master 1). Sits between the LSU / loader and the data RAM; issues at most one memory access per cycle, returns read data to the owning master one cycle later, and supports bounded locked bursts so the loader can stream words without interleaving.

## Interface
- ADDR_W, 32, byte address width for both masters and the memory
- LOCK_MAX, 16, maximum consecutive locked grants before forced release; legal range 2..255
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_m0_req / i_m1_req  in  1  access request, held until granted
- i_m0_we / i_m1_we  in  1  1 = write, 0 = read
- i_m0_addr / i_m1_addr  in  ADDR_W  byte address, word aligned
- i_m0_wdata / i_m1_wdata  in  32  store data
- i_m0_bmask / i_m1_bmask  in  4  byte enables for writes
- i_m0_lock / i_m1_lock  in  1  request to keep ownership on the next cycle
- o_m0_gnt / o_m1_gnt  out  1  access accepted this cycle
- o_m0_rvalid / o_m1_rvalid  out  1  read data valid, one cycle after a read grant
- o_m0_rdata / o_m1_rdata  out  32  read data, 0 when rvalid is low
- o_mem_en  out  1  memory access strobe
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  32  memory write data
- o_mem_bmask  out  4  memory byte enables
- i_mem_rdata  in  32  memory read data, valid the cycle after an o_mem_en read

## Operation
- States: IDLE (no owner), OWN0 (master 0 locked), OWN1 (master 1 locked).
- IDLE: a single requester is granted. On a double request the winner is chosen by the policy (see Configuration).
- The granted master's we/addr/wdata/bmask are muxed combinationally to o_mem_*; o_mem_en = granted. o_mem_* are 0 when there is no grant.
- Lock: if the granted master holds lock=1 with req=1, the next state is OWNx and lock_cnt increments. In OWNx only master x can be granted; the other master waits even if requesting.
- Release from OWNx to IDLE when the owner drops req or lock, or when lock_cnt reaches LOCK_MAX-1 while the other master is requesting (forced release). On forced release the other master must win the next arbitration regardless of policy.
- With no competing requester, lock_cnt saturates at LOCK_MAX-1 and ownership continues.
- Read tracking: a read grant registers rd_pend and rd_owner. On the next cycle o_mX_rvalid=1 and o_mX_rdata=i_mem_rdata go to rd_owner only. Write grants produce no rvalid.
- Back-to-back reads are supported; the rvalid stream mirrors the grant stream delayed by one cycle.

## Timing
- Grant latency: 0 cycles. A request seen in a cycle that permits it is granted and issued to memory in the same cycle.
- Read data latency: 1 cycle after gnt.
- Throughput: one access per cycle, and no idle cycle is inserted between different owners.
- Reset (synchronous, i_reset=1 at a clock edge): state=IDLE, lock_cnt=0, rr pointer=0 (master 0 preferred first), rd_pend=0.
- Output values while i_reset is held: all gnt, rvalid and o_mem_* are 0 and rdata is 0. A request asserted during reset is not granted.
- Reset while a read is pending: the pending rvalid is dropped.
- A master that drops req before being granted has no effect on arbitration state.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin on contention. After a grant to master x, the other master is preferred on the next contention. Locked cycles do not move the pointer; the release arbitration does.
- Not defined: fixed priority, master 0 (core) always wins on contention. Forced lock release still applies, so master 1 can hold at most LOCK_MAX cycles while master 0 waits.

## Test plan
- Single read: m0 read addr 0x10 while memory holds 0xDEADBEEF at word 4 -> o_m0_gnt=1 in the same cycle with o_mem_addr=0x10, then o_m0_rvalid=1 and o_m0_rdata=0xDEADBEEF on the next cycle; m1 rvalid stays 0.
- Contention: both masters request reads for 4 cycles -> with DMEM_ARB_RR_EN the grants go 0,1,0,1; without it they go 0,0,0,0.
- Locked burst: m1 writes 0x100..0x11C with lock=1 while m0 requests continuously, LOCK_MAX=4 -> m1 is granted 4 cycles, m0 is granted the 5th cycle, and m1 resumes afterward.
- Uncontended lock: m1 locks for 20 cycles with m0 idle -> 20 consecutive m1 grants and no forced release.
- Write then read: m0 writes 0x00000055 with bmask=0001 to 0x20, then reads 0x20 -> o_mem_we pulses once, and the read returns a low byte of 0x55 one cycle after its grant.
- Reset mid-read: read granted, then i_reset=1 on the next edge -> rvalid=0, no grants while reset is held, and m0 is granted first after release under contention.
